// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline register/source info in, stall/flush/forward controls out.
interface hazard_ctrl_if #(
  parameter int unsigned REG_W = 5
);

  logic [REG_W-1:0] RsD;
  logic [REG_W-1:0] RtD;
  logic [REG_W-1:0] RsE;
  logic [REG_W-1:0] RtE;
  logic [REG_W-1:0] WriteRegE;
  logic [REG_W-1:0] WriteRegM;
  logic [REG_W-1:0] WriteRegW;
  logic             RegWriteE;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             MemtoRegE;
  logic             MemtoRegM;
  logic             BranchD;
  logic             JumpD;
  logic             PCSrcD;
  logic             MdUseD;
  logic             MdStartE;

  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic             ForwardAD;
  logic             ForwardBD;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             MdBusy;

  // Hazard controller side
  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    input  BranchD, JumpD, PCSrcD, MdUseD, MdStartE,
    output StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
    output ForwardAE, ForwardBE, MdBusy
  );

  // Pipeline datapath side
  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    output BranchD, JumpD, PCSrcD, MdUseD, MdStartE,
    input  StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
    input  ForwardAE, ForwardBE, MdBusy
  );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage MIPS core.
// Detects load-use, branch-operand and mul/div hazards; drives stall/flush
// and forwarding selects. Optional macro HAZARD_BRANCH_FWD_EN enables Decode
// forwarding for branch comparators (shortening branch-after-ALU stalls).
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned REG_W      = 5
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;

  logic       w_lwstall;
  logic       w_branchstall;
  logic       w_mdstall;
  logic       w_stall;
  logic       w_flush_d;
  logic       w_fwd_ad;
  logic       w_fwd_bd;
  logic [1:0] w_fwd_ae;
  logic [1:0] w_fwd_be;
  logic       w_e_hit_d;
  logic       w_m_hit_d;
  logic       w_busy;

  // A stage hits a source when it writes a nonzero register equal to that source
  function automatic logic reg_hit(input logic we, input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] src);
    return we && (dst != '0) && (dst == src);
  endfunction

  // Execute forwarding selects: M result has priority over W result
  always_comb begin
    w_fwd_ae = 2'b00;
    w_fwd_be = 2'b00;
    if (reg_hit(bus.RegWriteM, bus.WriteRegM, bus.RsE)) begin
      w_fwd_ae = 2'b10;
    end else if (reg_hit(bus.RegWriteW, bus.WriteRegW, bus.RsE)) begin
      w_fwd_ae = 2'b01;
    end
    if (reg_hit(bus.RegWriteM, bus.WriteRegM, bus.RtE)) begin
      w_fwd_be = 2'b10;
    end else if (reg_hit(bus.RegWriteW, bus.WriteRegW, bus.RtE)) begin
      w_fwd_be = 2'b01;
    end
  end

  assign w_e_hit_d = reg_hit(bus.RegWriteE, bus.WriteRegE, bus.RsD) ||
                     reg_hit(bus.RegWriteE, bus.WriteRegE, bus.RtD);
  assign w_m_hit_d = reg_hit(bus.RegWriteM, bus.WriteRegM, bus.RsD) ||
                     reg_hit(bus.RegWriteM, bus.WriteRegM, bus.RtD);

  assign w_lwstall = bus.MemtoRegE && (bus.WriteRegE != '0) &&
                     ((bus.WriteRegE == bus.RsD) || (bus.WriteRegE == bus.RtD));

`ifdef HAZARD_BRANCH_FWD_EN
  // Branch operands can come from M via the Decode bypass unless M is a load
  assign w_fwd_ad      = reg_hit(bus.RegWriteM, bus.WriteRegM, bus.RsD);
  assign w_fwd_bd      = reg_hit(bus.RegWriteM, bus.WriteRegM, bus.RtD);
  assign w_branchstall = bus.BranchD && (w_e_hit_d || (bus.MemtoRegM && w_m_hit_d));
`else
  // No Decode bypass: a branch waits until its producer reaches W
  logic w_unused_memtoreg_m;
  assign w_unused_memtoreg_m = bus.MemtoRegM;
  assign w_fwd_ad      = 1'b0;
  assign w_fwd_bd      = 1'b0;
  assign w_branchstall = bus.BranchD && (w_e_hit_d || w_m_hit_d);
`endif

  assign w_busy    = (r_state == BUSY);
  assign w_mdstall = w_busy && bus.MdUseD;
  assign w_stall   = w_lwstall || w_branchstall || w_mdstall;
  assign w_flush_d = (bus.PCSrcD || bus.JumpD) && !w_stall;

  // Outputs forced low while reset is asserted
  assign bus.StallF    = !reset && w_stall;
  assign bus.StallD    = !reset && w_stall;
  assign bus.FlushE    = !reset && w_stall;
  assign bus.FlushD    = !reset && w_flush_d;
  assign bus.ForwardAD = !reset && w_fwd_ad;
  assign bus.ForwardBD = !reset && w_fwd_bd;
  assign bus.ForwardAE = reset ? 2'b00 : w_fwd_ae;
  assign bus.ForwardBE = reset ? 2'b00 : w_fwd_be;
  assign bus.MdBusy    = !reset && w_busy;

  // Mul/div occupancy tracker; a start while busy restarts the window
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.MdStartE) begin
            r_state <= BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (bus.MdStartE) begin
            r_cnt <= CNT_LOAD;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MD_LATENCY=4).
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  hazard_ctrl_if #(.REG_W(5)) hif ();

  hazard_ctrl #(.MD_LATENCY(4), .REG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check_eq({tag, ".StallF"}, 32'(hif.StallF), 32'(exp));
    check_eq({tag, ".StallD"}, 32'(hif.StallD), 32'(exp));
    check_eq({tag, ".FlushE"}, 32'(hif.FlushE), 32'(exp));
  endtask

  task automatic clear_inputs();
    hif.RsD = '0; hif.RtD = '0; hif.RsE = '0; hif.RtE = '0;
    hif.WriteRegE = '0; hif.WriteRegM = '0; hif.WriteRegW = '0;
    hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.MemtoRegE = 1'b0; hif.MemtoRegM = 1'b0;
    hif.BranchD = 1'b0; hif.JumpD = 1'b0; hif.PCSrcD = 1'b0;
    hif.MdUseD = 1'b0; hif.MdStartE = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs change here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling
  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    reset = 1'b1;

    // Reset: outputs forced low even with hazards on the inputs
    step();
    hif.MemtoRegE = 1'b1; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd5; hif.RsD = 5'd5;
    hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd9; hif.RsE = 5'd9; hif.JumpD = 1'b1;
    settle();
    check_stall("rst", 1'b0);
    check_eq("rst.FlushD", 32'(hif.FlushD), 32'd0);
    check_eq("rst.ForwardAE", 32'(hif.ForwardAE), 32'd0);
    check_eq("rst.MdBusy", 32'(hif.MdBusy), 32'd0);
    step();
    reset = 1'b0;
    clear_inputs();
    settle();
    check_eq("post_rst.MdBusy", 32'(hif.MdBusy), 32'd0);

    // Load-use: one stall cycle, released when the load moves to M
    step();
    hif.MemtoRegE = 1'b1; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd5; hif.RsD = 5'd5;
    settle();
    check_stall("lw_c1", 1'b1);
    step();
    clear_inputs();
    hif.RsD = 5'd5; hif.MemtoRegM = 1'b1; hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd5;
    settle();
    check_stall("lw_c2", 1'b0);

    // Execute forwarding priority
    step();
    clear_inputs();
    hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
    hif.WriteRegM = 5'd8; hif.WriteRegW = 5'd8; hif.RsE = 5'd8; hif.RtE = 5'd0;
    settle();
    check_eq("fwd_ae_m", 32'(hif.ForwardAE), 32'd2);
    check_eq("fwd_be_r0", 32'(hif.ForwardBE), 32'd0);
    hif.WriteRegM = 5'd0;
    settle();
    check_eq("fwd_ae_w", 32'(hif.ForwardAE), 32'd1);
    hif.WriteRegM = 5'd8; hif.RtE = 5'd8;
    settle();
    check_eq("fwd_be_m", 32'(hif.ForwardBE), 32'd2);
    hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    settle();
    check_eq("fwd_ae_nowe", 32'(hif.ForwardAE), 32'd0);

    // Branch after load: two stall cycles
    step();
    clear_inputs();
    hif.BranchD = 1'b1; hif.RsD = 5'd3;
    hif.RegWriteE = 1'b1; hif.MemtoRegE = 1'b1; hif.WriteRegE = 5'd3;
    settle();
    check_stall("bld_c1", 1'b1);
    check_eq("bld_c1.FlushD", 32'(hif.FlushD), 32'd0);
    step();
    hif.RegWriteE = 1'b0; hif.MemtoRegE = 1'b0; hif.WriteRegE = 5'd0;
    hif.RegWriteM = 1'b1; hif.MemtoRegM = 1'b1; hif.WriteRegM = 5'd3;
    settle();
    check_stall("bld_c2", 1'b1);
    step();
    hif.RegWriteM = 1'b0; hif.MemtoRegM = 1'b0; hif.WriteRegM = 5'd0;
    hif.RegWriteW = 1'b1; hif.WriteRegW = 5'd3;
    settle();
    check_stall("bld_c3", 1'b0);
    check_eq("bld_c3.ForwardAD", 32'(hif.ForwardAD), 32'd0);

    // Branch after ALU op
    step();
    clear_inputs();
    hif.BranchD = 1'b1; hif.RsD = 5'd3; hif.RtD = 5'd3;
    hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd3;
    settle();
    check_stall("balu_c1", 1'b1);
    step();
    hif.RegWriteE = 1'b0; hif.WriteRegE = 5'd0;
    hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd3;
    settle();
`ifdef HAZARD_BRANCH_FWD_EN
    check_stall("balu_c2", 1'b0);
    check_eq("balu_c2.ForwardAD", 32'(hif.ForwardAD), 32'd1);
    check_eq("balu_c2.ForwardBD", 32'(hif.ForwardBD), 32'd1);
`else
    check_stall("balu_c2", 1'b1);
    check_eq("balu_c2.ForwardAD", 32'(hif.ForwardAD), 32'd0);
    check_eq("balu_c2.ForwardBD", 32'(hif.ForwardBD), 32'd0);
`endif
    step();
    hif.RegWriteM = 1'b0; hif.WriteRegM = 5'd0;
    hif.RegWriteW = 1'b1; hif.WriteRegW = 5'd3;
    settle();
    check_stall("balu_c3", 1'b0);

    // Taken branch / jump flush, suppressed while stalled
    step();
    clear_inputs();
    hif.BranchD = 1'b1; hif.PCSrcD = 1'b1; hif.RsD = 5'd1; hif.RtD = 5'd7;
    settle();
    check_eq("tkn.FlushD", 32'(hif.FlushD), 32'd1);
    check_eq("tkn.StallD", 32'(hif.StallD), 32'd0);
    hif.MemtoRegE = 1'b1; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd7;
    settle();
    check_eq("tkn_lw.FlushD", 32'(hif.FlushD), 32'd0);
    check_eq("tkn_lw.StallD", 32'(hif.StallD), 32'd1);
    clear_inputs();
    hif.JumpD = 1'b1;
    settle();
    check_eq("jmp.FlushD", 32'(hif.FlushD), 32'd1);

    // Mul/div: busy t+1..t+4, MdUseD stalls from t+2 until t+5
    step();
    clear_inputs();
    hif.MdStartE = 1'b1;
    settle();
    check_eq("md_t0.MdBusy", 32'(hif.MdBusy), 32'd0);
    step();
    hif.MdStartE = 1'b0;
    settle();
    check_eq("md_t1.MdBusy", 32'(hif.MdBusy), 32'd1);
    check_stall("md_t1", 1'b0);
    for (int k = 2; k <= 4; k++) begin
      step();
      hif.MdUseD = 1'b1;
      settle();
      check_eq($sformatf("md_t%0d.MdBusy", k), 32'(hif.MdBusy), 32'd1);
      check_stall($sformatf("md_t%0d", k), 1'b1);
    end
    step();
    settle();
    check_eq("md_t5.MdBusy", 32'(hif.MdBusy), 32'd0);
    check_stall("md_t5", 1'b0);

    // Start while busy restarts the 4-cycle window
    step();
    clear_inputs();
    hif.MdStartE = 1'b1;
    step();
    hif.MdStartE = 1'b0;
    step();
    hif.MdStartE = 1'b1;
    step();
    hif.MdStartE = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      settle();
      check_eq($sformatf("mdre_t%0d.MdBusy", k), 32'(hif.MdBusy), 32'd1);
      step();
    end
    settle();
    check_eq("mdre_t7.MdBusy", 32'(hif.MdBusy), 32'd0);

    // Reset during mul/div abandons it
    step();
    clear_inputs();
    hif.MdStartE = 1'b1;
    step();
    hif.MdStartE = 1'b0;
    step();
    reset = 1'b1;
    hif.MdUseD = 1'b1;
    hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd4; hif.RsE = 5'd4; hif.RsD = 5'd4;
    settle();
    check_eq("mdrst.MdBusy", 32'(hif.MdBusy), 32'd0);
    check_stall("mdrst", 1'b0);
    check_eq("mdrst.ForwardAE", 32'(hif.ForwardAE), 32'd0);
    check_eq("mdrst.ForwardAD", 32'(hif.ForwardAD), 32'd0);
    step();
    reset = 1'b0;
    clear_inputs();
    settle();
    check_eq("mdrst_rel.MdBusy", 32'(hif.MdBusy), 32'd0);
    step();
    hif.MdStartE = 1'b1;
    step();
    hif.MdStartE = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      settle();
      check_eq($sformatf("mdnew_t%0d.MdBusy", k), 32'(hif.MdBusy), 32'd1);
      step();
    end
    settle();
    check_eq("mdnew_t5.MdBusy", 32'(hif.MdBusy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
